// File: rtl/simple_adder_pkg.sv
// ============================================================================
// Module  : simple_adder_pkg
// Brief   : Shared constants and helpers for the simple_adder ripple adder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package simple_adder_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int MAX_WIDTH     = 64;

    // Reset values of the registered outputs; SUM_RST is sliced to WIDTH.
    localparam logic [MAX_WIDTH-1:0] SUM_RST   = '0;
    localparam logic                 CARRY_RST = 1'b0;
    localparam logic                 OVF_RST   = 1'b0;
    localparam logic                 VALID_RST = 1'b0;

    // Two's-complement overflow: like-signed operands yielding an opposite-signed sum.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder_cell.sv
// ============================================================================
// Module  : full_adder_cell
// Brief   : One-bit full adder used as a stage of the ripple-carry chain.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_half;

    assign w_half = x ^ y;
    assign s      = w_half ^ ci;
    assign co     = (x & y) | (ci & w_half);

endmodule

`default_nettype wire

// File: rtl/simple_adder.sv
// ============================================================================
// Module  : simple_adder
// Brief   : Ripple-carry adder with combinational sum/carry and a one-cycle
//           registered copy plus signed-overflow flag.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module simple_adder
    import simple_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             ovf_q,
    output logic             out_valid
);

    logic [WIDTH:0] w_carry;
    logic           w_ovf;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_cell u_cell (
            .x  (a[i]),
            .y  (b[i]),
            .ci (w_carry[i]),
            .s  (sum[i]),
            .co (w_carry[i+1])
        );
    end

    assign carry = w_carry[WIDTH];
    assign w_ovf = signed_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);

    // Result fields hold while idle; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= SUM_RST[WIDTH-1:0];
            carry_q   <= CARRY_RST;
            ovf_q     <= OVF_RST;
            out_valid <= VALID_RST;
        end else if (in_valid) begin
            sum_q     <= sum;
            carry_q   <= carry;
            ovf_q     <= w_ovf;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_simple_adder.sv
// ============================================================================
// Module  : tb_simple_adder
// Brief   : Directed bench for simple_adder at WIDTH=1 and WIDTH=8.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_simple_adder;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       a1 = 1'b0, b1 = 1'b0;
    logic       sum1, carry1, sum_q1, carry_q1, ovf_q1, out_valid1;

    logic [7:0] a8 = '0, b8 = '0;
    logic       in_valid8 = 1'b0;
    logic [7:0] sum8, sum_q8;
    logic       carry8, carry_q8, ovf_q8, out_valid8;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    simple_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(1'b0),
        .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1),
        .ovf_q(ovf_q1), .out_valid(out_valid1)
    );

    simple_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(in_valid8),
        .sum(sum8), .carry(carry8), .sum_q(sum_q8), .carry_q(carry_q8),
        .ovf_q(ovf_q8), .out_valid(out_valid8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every registered output must match the oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (out_valid8) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_valid_unexpected: got 1 expected 0 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_sum_q",   64'(sum_q8),   64'(e.s));
                check("sb_carry_q", 64'(carry_q8), 64'(e.c));
                check("sb_ovf_q",   64'(ovf_q8),   64'(e.o));
            end
        end
    end

    initial begin
        vec_t vecs[7];
        vecs[0] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0};
        vecs[5] = '{8'hC0, 8'hC0, 8'h80, 1'b1, 1'b0};
        vecs[6] = '{8'h40, 8'h40, 8'h80, 1'b0, 1'b1};

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        a8 = 8'h21; b8 = 8'h13;
        #1;
        check("rst_sum_q",     64'(sum_q8),     64'h0);
        check("rst_carry_q",   64'(carry_q8),   64'h0);
        check("rst_ovf_q",     64'(ovf_q8),     64'h0);
        check("rst_out_valid", 64'(out_valid8), 64'h0);
        check("rst_sum_comb",  64'(sum8),       64'h34);

        // WIDTH=1 exhaustive: {a,b} -> {sum,carry}
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            logic [1:0] exp_sc [4];
            exp_sc[0] = 2'b00; exp_sc[1] = 2'b10; exp_sc[2] = 2'b10; exp_sc[3] = 2'b01;
            ab = 2'(i);
            a1 = ab[1]; b1 = ab[0];
            #10;
            check("w1_sum",   64'(sum1),   64'(exp_sc[i][1]));
            check("w1_carry", 64'(carry1), 64'(exp_sc[i][0]));
        end

        // WIDTH=1 toggle pattern.
        for (int i = 0; i < 10; i++) begin
            a1 = 1'(i % 2); b1 = 1'((i + 1) % 2);
            #10;
            check("w1_tog_sum",   64'(sum1),   64'h1);
            check("w1_tog_carry", 64'(carry1), 64'h0);
        end

        @(negedge clk) rst_n = 1'b1;

        // Back-to-back valid stream.
        foreach (vecs[i]) begin
            @(negedge clk);
            a8 = vecs[i].a; b8 = vecs[i].b; in_valid8 = 1'b1;
            exp_q.push_back('{vecs[i].s, vecs[i].c, vecs[i].o});
            #1;
            check("comb_sum",   64'(sum8),   64'(vecs[i].s));
            check("comb_carry", 64'(carry8), 64'(vecs[i].c));
        end

        // Idle for three cycles: result holds, valid drops.
        @(negedge clk);
        in_valid8 = 1'b0; a8 = 8'h01; b8 = 8'h01;
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_out_valid", 64'(out_valid8), 64'h0);
            check("hold_sum_q",     64'(sum_q8),     64'h80);
            check("hold_carry_q",   64'(carry_q8),   64'h0);
            check("hold_ovf_q",     64'(ovf_q8),     64'h1);
        end

        // Mid-stream reset discards the in-flight item.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; in_valid8 = 1'b1;
        exp_q.push_back('{8'h46, 1'b0, 1'b0});
        @(negedge clk);
        a8 = 8'h70; b8 = 8'h20;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sum_q",     64'(sum_q8),     64'h0);
        check("mid_rst_carry_q",   64'(carry_q8),   64'h0);
        check("mid_rst_ovf_q",     64'(ovf_q8),     64'h0);
        check("mid_rst_out_valid", 64'(out_valid8), 64'h0);
        check("mid_rst_sum_comb",  64'(sum8),       64'h90);
        @(posedge clk); #1;
        check("rst_held_out_valid", 64'(out_valid8), 64'h0);
        check("rst_held_sum_q",     64'(sum_q8),     64'h0);

        // First capture is on the first edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{8'h90, 1'b0, 1'b1});
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);

        check("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/simple_adder.md
SIMPLE_ADDER -- requirements
Module: simple_adder

Interface
REQ-001 Parameter: WIDTH, default 1, operand/sum bit width (legal 1..64).
REQ-002 Port: clk  input  1  single clock; rising-edge active.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: a  input  WIDTH  operand A, unsigned/two's-complement agnostic.
REQ-005 Port: b  input  WIDTH  operand B.
REQ-006 Port: in_valid  input  1  qualifies a/b for the registered path.
REQ-007 Port: sum  output  WIDTH  combinational modulo-2^WIDTH sum of a and b.
REQ-008 Port: carry  output  1  combinational carry-out of a+b.
REQ-009 Port: sum_q  output  WIDTH  registered sum.
REQ-010 Port: carry_q  output  1  registered carry-out.
REQ-011 Port: ovf_q  output  1  registered signed-overflow flag.
REQ-012 Port: out_valid  output  1  registered-path valid.

Function
REQ-013 sum SHALL equal (a + b) mod 2^WIDTH with zero latency and no dependence on clk, rst_n or in_valid.
REQ-014 For WIDTH=1, sum SHALL equal a XOR b and carry SHALL equal a AND b.
REQ-015 carry SHALL equal bit WIDTH of the (WIDTH+1)-bit sum a + b.
REQ-016 The adder SHALL be a ripple-carry chain of WIDTH full-adder cells, bit 0 carry-in tied to 0.
REQ-017 On each rising clk with in_valid=1: sum_q<=sum, carry_q<=carry, ovf_q<=(a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), out_valid<=1.
REQ-018 On each rising clk with in_valid=0: sum_q, carry_q, ovf_q SHALL hold; out_valid<=0.
REQ-019 Registered-path latency SHALL be exactly one cycle; back-to-back valid inputs SHALL be accepted every cycle (no stall, no backpressure).
REQ-020 Wrap-around: all-ones + 1 SHALL give sum=0, carry=1.
REQ-021 Combinational outputs SHALL be free of X for any 0/1 inputs and SHALL settle within one evaluation (no latches).

Reset
REQ-022 rst_n low SHALL immediately (asynchronously) force sum_q=0, carry_q=0, ovf_q=0, out_valid=0.
REQ-023 Reset SHALL NOT affect sum or carry.
REQ-024 Release of rst_n SHALL be synchronous-safe: first capture occurs on the first rising clk with rst_n high.
REQ-025 Reset asserted mid-stream SHALL discard the in-flight result; no valid output is produced for it.

Structure
REQ-026 Shared package simple_adder_pkg SHALL hold the default WIDTH constant and the reset value constants for registered outputs.
REQ-027 One sub-module, full_adder_cell (inputs x, y, ci; outputs s, co), SHALL be instantiated WIDTH times via generate.
REQ-028 Registered outputs SHALL be implemented in a single always block with async reset; no other sequential logic.

Verification
REQ-029 WIDTH=1, exhaustive: (a,b)=(0,0)->sum 0; (0,1)->1; (1,0)->1; (1,1)->sum 0, carry 1, each checked 10 ns after apply, no clock needed.
REQ-030 WIDTH=1 toggle: 10 steps a=i%2, b=(i+1)%2 -> sum=1, carry=0 every step.
REQ-031 WIDTH=8: a=8'hFF, b=8'h01, in_valid=1 -> sum=0, carry=1 immediately; next edge sum_q=0, carry_q=1, ovf_q=0, out_valid=1.
REQ-032 WIDTH=8: a=8'h7F, b=8'h01 -> sum=8'h80, carry=0, ovf_q=1 after one edge.
REQ-033 Reset: drive valid stream, pull rst_n low between edges -> sum_q/carry_q/ovf_q/out_valid all 0 before next edge; sum still tracks a+b.
REQ-034 in_valid=0 for 3 cycles after a valid result -> sum_q holds value, out_valid=0.
